// File: rtl/ovc_reg_pkg.sv
// Shared types and defaults for the host register bank with shadow/active double buffering.
package ovc_reg_pkg;

    localparam int unsigned DATA_W_DEF = 32;
    localparam int unsigned ADDR_W_DEF = 8;
    localparam int unsigned N_LIVE_DEF = 16;
    localparam int unsigned VALID_BIT  = 0;

    typedef enum logic {
        IDLE    = 1'b0,
        PENDING = 1'b1
    } state_t;

    typedef enum logic [1:0] {
        REG_LIVE    = 2'd0,
        REG_SCRATCH = 2'd1,
        REG_STATUS  = 2'd2
    } region_t;

    // Map a word address onto the region that owns it.
    function automatic region_t addr_region(input int unsigned a,
                                            input int unsigned n_live,
                                            input int unsigned status_base);
        if (a < n_live) begin
            return REG_LIVE;
        end
        if (a < status_base) begin
            return REG_SCRATCH;
        end
        return REG_STATUS;
    endfunction

endpackage

// File: rtl/ovc_be_ram.sv
// Single-port-write RAM with byte enables; combinational read sampled by the caller's register,
// which yields read-before-write when both happen on the same edge.
module ovc_be_ram #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 8
) (
    input  logic                clk,
    input  logic                we,
    input  logic [DATA_W/8-1:0] be,
    input  logic [ADDR_W-1:0]   waddr,
    input  logic [DATA_W-1:0]   wdata,
    input  logic [ADDR_W-1:0]   raddr,
    output logic [DATA_W-1:0]   rdata_c
);
    localparam int unsigned NB = DATA_W / 8;

    logic [DATA_W-1:0] mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (we) begin
            for (int b = 0; b < NB; b++) begin
                if (be[b]) begin
                    mem[waddr][b*8 +: 8] <= wdata[b*8 +: 8];
                end
            end
        end
    end

    assign rdata_c = mem[raddr];

endmodule

// File: rtl/ovc_reg_bank.sv
// Host register bank: shadow registers committed atomically to the active copy on frame_sync,
// plus host scratch RAM and a fabric-written status RAM.
module ovc_reg_bank
    import ovc_reg_pkg::*;
#(
    parameter int unsigned DATA_W      = DATA_W_DEF,
    parameter int unsigned ADDR_W      = ADDR_W_DEF,
    parameter int unsigned N_LIVE      = N_LIVE_DEF,
    parameter int unsigned STATUS_BASE = 2 ** (ADDR_W - 1)
) (
    input  logic                       c,
    input  logic                       rst_n,
    input  logic [ADDR_W-1:0]          addr,
    input  logic                       wr,
    input  logic [DATA_W/8-1:0]        be,
    input  logic [DATA_W-1:0]          d,
    output logic [DATA_W-1:0]          q,
    input  logic                       st_wr,
    input  logic [ADDR_W-1:0]          st_addr,
    input  logic [DATA_W-1:0]          st_d,
    input  logic                       frame_sync,
    output logic [N_LIVE*DATA_W-1:0]   live,
    output logic                       committed,
    output logic                       pending,
    output logic [15:0]                commit_cnt
);
    localparam int unsigned NB = DATA_W / 8;
    localparam int unsigned LW = N_LIVE * DATA_W;

    state_t            state;
    state_t            next_state;
    logic [LW-1:0]     shadow;
    region_t           host_region_c;
    logic              host_v0_c;
    logic              commit_c;
    logic              scratch_we_c;
    logic              status_we_c;
    logic [DATA_W-1:0] scratch_rdata_c;
    logic [DATA_W-1:0] status_rdata_c;
    logic [DATA_W-1:0] rdata_c;

    // Address decode for both access ports.
    always_comb begin
        host_region_c = addr_region(32'(addr), N_LIVE, STATUS_BASE);
        host_v0_c     = wr && (addr == '0) && be[0];
        scratch_we_c  = wr && (host_region_c == REG_SCRATCH);
        status_we_c   = st_wr && (32'(st_addr) >= STATUS_BASE);
    end

    always_ff @(posedge c or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // A write touching the valid bit decides the next state even when it collides with a commit.
    always_comb begin
        next_state = state;
        commit_c   = 1'b0;
        case (state)
            IDLE: begin
                if (host_v0_c && d[VALID_BIT]) begin
                    next_state = PENDING;
                end
            end
            PENDING: begin
                commit_c = frame_sync;
                if (host_v0_c) begin
                    next_state = d[VALID_BIT] ? PENDING : IDLE;
                end else if (frame_sync) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Shadow/active datapath; host byte writes land after the commit clear so they win.
    always_ff @(posedge c or negedge rst_n) begin
        if (!rst_n) begin
            shadow     <= '0;
            live       <= '0;
            commit_cnt <= '0;
            committed  <= 1'b0;
            pending    <= 1'b0;
            q          <= '0;
        end else begin
            committed <= commit_c;
            pending   <= (next_state == PENDING);
            q         <= rdata_c;
            if (commit_c) begin
                live              <= shadow;
                shadow[VALID_BIT] <= 1'b0;
                commit_cnt        <= commit_cnt + 16'd1;
            end
            for (int i = 0; i < N_LIVE; i++) begin
                for (int b = 0; b < NB; b++) begin
                    if (wr && (addr == ADDR_W'(i)) && be[b]) begin
                        shadow[i*DATA_W + b*8 +: 8] <= d[b*8 +: 8];
                    end
                end
            end
        end
    end

    // Host read mux; live addresses return the shadow copy.
    always_comb begin
        rdata_c = '0;
        case (host_region_c)
            REG_LIVE: begin
                for (int i = 0; i < N_LIVE; i++) begin
                    if (addr == ADDR_W'(i)) begin
                        rdata_c = shadow[i*DATA_W +: DATA_W];
                    end
                end
            end
            REG_SCRATCH: rdata_c = scratch_rdata_c;
            default:     rdata_c = status_rdata_c;
        endcase
    end

    ovc_be_ram #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_scratch (
        .clk     (c),
        .we      (scratch_we_c),
        .be      (be),
        .waddr   (addr),
        .wdata   (d),
        .raddr   (addr),
        .rdata_c (scratch_rdata_c)
    );

    ovc_be_ram #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_status (
        .clk     (c),
        .we      (status_we_c),
        .be      ({NB{1'b1}}),
        .waddr   (st_addr),
        .wdata   (st_d),
        .raddr   (addr),
        .rdata_c (status_rdata_c)
    );

endmodule
